// File: rtl/rs232_byte_fifo_if.sv
// Byte handshake bundle between rs232_des, the byte FIFO and rs232_ser.
// The FIFO uses the slave view; the surrounding logic (or a bench) uses master.
interface rs232_byte_fifo_if #(
  parameter int P_DEPTH_LOG2 = 4
);
  logic [7:0]            in_data;
  logic                  in_req;
  logic                  in_ack;
  logic [7:0]            out_data;
  logic                  out_req;
  logic                  out_ack;
  logic [P_DEPTH_LOG2:0] count;
  logic                  overflow;

  modport slave (
    input  in_data, in_req, out_ack,
    output in_ack, out_data, out_req, count, overflow
  );

  modport master (
    output in_data, in_req, out_ack,
    input  in_ack, out_data, out_req, count, overflow
  );
endinterface

// File: rtl/rs232_byte_fifo.sv
// Elastic byte buffer between the RS232 deserializer and serializer.
// req/ack on both sides; bytes arriving while full are dropped and flagged in a sticky overflow.
module rs232_byte_fifo #(
  parameter int P_DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rs232_byte_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << P_DEPTH_LOG2;
  localparam logic [P_DEPTH_LOG2:0] FULL = (P_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {
    IN_IDLE,
    IN_WAIT
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_REQ,
    OUT_GAP
  } out_state_t;

  logic [7:0]              mem [DEPTH];
  logic [P_DEPTH_LOG2-1:0] wr_ptr;
  logic [P_DEPTH_LOG2-1:0] rd_ptr;
  logic [P_DEPTH_LOG2:0]   count_q;
  logic                    in_ack_q;
  logic                    out_req_q;
  logic [7:0]              out_data_q;
  logic                    overflow_q;

  in_state_t  in_state, in_next;
  out_state_t out_state, out_next;

  logic push;
  logic drop;
  logic in_ack_d;
  logic load;
  logic pop;

  // Input side: one byte per in_req assertion; full test uses count at the start of the cycle.
  always_comb begin
    in_next  = in_state;
    push     = 1'b0;
    drop     = 1'b0;
    in_ack_d = 1'b0;
    case (in_state)
      IN_IDLE: begin
        if (bus.in_req) begin
          in_ack_d = 1'b1;
          in_next  = IN_WAIT;
          if (count_q < FULL) push = 1'b1;
          else                drop = 1'b1;
        end
      end
      IN_WAIT: begin
        if (!bus.in_req) in_next = IN_IDLE;
      end
      default: in_next = IN_IDLE;
    endcase
  end

  // Output side: present, wait for ack, then one idle gap cycle before the next byte.
  always_comb begin
    out_next = out_state;
    load     = 1'b0;
    pop      = 1'b0;
    case (out_state)
      OUT_IDLE: begin
        if (count_q != '0) begin
          load     = 1'b1;
          out_next = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (bus.out_ack) begin
          pop      = 1'b1;
          out_next = OUT_GAP;
        end
      end
      OUT_GAP:  out_next = OUT_IDLE;
      default:  out_next = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state   <= IN_IDLE;
      out_state  <= OUT_IDLE;
      in_ack_q   <= 1'b0;
      out_req_q  <= 1'b0;
      out_data_q <= 8'h00;
      overflow_q <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
      in_ack_q  <= in_ack_d;
      if (load) begin
        out_req_q  <= 1'b1;
        out_data_q <= mem[rd_ptr];
      end else if (pop) begin
        out_req_q <= 1'b0;
      end
      if (drop) overflow_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage holds no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  assign bus.in_ack   = in_ack_q;
  assign bus.out_req  = out_req_q;
  assign bus.out_data = out_data_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_rs232_byte_fifo.sv
// Self-checking bench for rs232_byte_fifo: directed scenarios plus randomized traffic
// compared against a queue model of the buffer.
module tb_rs232_byte_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs232_byte_fifo_if #(.P_DEPTH_LOG2(4)) bus ();
  rs232_byte_fifo #(.P_DEPTH_LOG2(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] mq [$];
  bit m_ovf;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_req = 1'b0; bus.out_ack = 1'b0; bus.in_data = 8'h00;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    mq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, output bit acked);
    acked = 1'b0;
    bus.in_data = b;
    bus.in_req = 1'b1;
    for (int i = 0; i < 5 && !acked; i++) begin
      tick();
      if (bus.in_ack === 1'b1) acked = 1'b1;
    end
    bus.in_req = 1'b0;
    tick();
    if (acked) begin
      if (mq.size() < 16) mq.push_back(b);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic recv(input int dly, output logic [7:0] b, output bit got, output bit stable);
    got = 1'b0; stable = 1'b1; b = 8'h00;
    for (int i = 0; i < 60 && !got; i++) begin
      if (bus.out_req === 1'b1) got = 1'b1;
      else tick();
    end
    if (got) begin
      b = bus.out_data;
      repeat (dly) begin
        tick();
        if (bus.out_req !== 1'b1 || bus.out_data !== b) stable = 1'b0;
      end
      bus.out_ack = 1'b1;
      tick();
      bus.out_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.in_req = 1'b0; bus.out_ack = 1'b0; bus.in_data = 8'h00;
    #2;
    n_tests++; if (bus.in_ack !== 1'b0) begin n_fail++; $display("FAIL reset_in_ack: got %0b want 0", bus.in_ack); end
    n_tests++; if (bus.out_req !== 1'b0) begin n_fail++; $display("FAIL reset_out_req: got %0b want 0", bus.out_req); end
    n_tests++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %0h want 00", bus.out_data); end
    n_tests++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", bus.overflow); end
    do_reset();
  endtask

  task automatic test_single();
    bit seen;
    do_reset();
    bus.in_data = 8'h41; bus.in_req = 1'b1;
    tick();
    n_tests++; if (bus.in_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack_n1: got %0b want 1", bus.in_ack); end
    n_tests++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL single_count_n1: got %0d want 1", bus.count); end
    n_tests++; if (bus.out_req !== 1'b0) begin n_fail++; $display("FAIL single_req_n1: got %0b want 0", bus.out_req); end
    bus.in_req = 1'b0;
    tick();
    n_tests++; if (bus.in_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_n2: got %0b want 0", bus.in_ack); end
    n_tests++; if (bus.out_req !== 1'b1) begin n_fail++; $display("FAIL single_req_n2: got %0b want 1", bus.out_req); end
    n_tests++; if (bus.out_data !== 8'h41) begin n_fail++; $display("FAIL single_data: got %0h want 41", bus.out_data); end
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    n_tests++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL single_count_end: got %0d want 0", bus.count); end
    seen = 1'b0;
    repeat (4) begin
      if (bus.out_req !== 1'b0) seen = 1'b1;
      tick();
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL single_req_after: got %0b want 0", seen); end
  endtask

  task automatic test_fill_order();
    bit a, got, st;
    logic [7:0] b, exp;
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i), a);
    n_tests++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d want 16", bus.count); end
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_clear: got %0b want 0", bus.overflow); end
    send(8'hFF, a);
    n_tests++; if (a !== 1'b1) begin n_fail++; $display("FAIL fill_drop_ack: got %0b want 1", a); end
    n_tests++; if (bus.overflow !== m_ovf) begin n_fail++; $display("FAIL fill_ovf_set: got %0b want %0b", bus.overflow, m_ovf); end
    n_tests++; if (int'(bus.count) !== mq.size()) begin n_fail++; $display("FAIL fill_count_full: got %0d want %0d", bus.count, mq.size()); end
    for (int i = 0; i < 16; i++) begin
      recv(0, b, got, st);
      exp = mq.pop_front();
      n_tests++; if (!got || b !== exp) begin n_fail++; $display("FAIL fill_drain[%0d]: got %0h (req %0b) want %0h", i, b, got, exp); end
    end
    n_tests++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL fill_count_end: got %0d want 0", bus.count); end
  endtask

  task automatic test_wrap();
    bit a, got, st;
    logic [7:0] b, exp, base;
    int sent, rcvd;
    do_reset();
    base = 8'($urandom);
    sent = 0; rcvd = 0;
    while (rcvd < 40) begin
      if (sent < 40 && (sent == rcvd || ($urandom_range(0, 1) == 1 && mq.size() < 16))) begin
        send(8'(base + 8'(sent)), a);
        sent++;
      end else begin
        recv($urandom_range(0, 5), b, got, st);
        exp = mq.pop_front();
        rcvd++;
        n_tests++; if (!got || b !== exp || !st) begin n_fail++; $display("FAIL wrap_data[%0d]: got %0h (req %0b stable %0b) want %0h", rcvd, b, got, st, exp); end
      end
      n_tests++; if (int'(bus.count) !== mq.size() || bus.count > 5'd16) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", bus.count, mq.size()); end
    end
  endtask

  task automatic test_simultaneous();
    bit a, got, st;
    logic [7:0] b, exp, head;
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), a);
    for (int i = 0; i < 10 && bus.out_req !== 1'b1; i++) tick();
    head = bus.out_data;
    bus.in_data = 8'hA5; bus.in_req = 1'b1; bus.out_ack = 1'b1;
    tick();
    n_tests++; if (bus.count !== 5'd5) begin n_fail++; $display("FAIL simul_count5: got %0d want 5", bus.count); end
    n_tests++; if (bus.in_ack !== 1'b1 || bus.out_req !== 1'b0) begin n_fail++; $display("FAIL simul_hs5: got ack %0b req %0b want 1 0", bus.in_ack, bus.out_req); end
    bus.in_req = 1'b0; bus.out_ack = 1'b0;
    tick();
    exp = mq.pop_front();
    mq.push_back(8'hA5);
    n_tests++; if (head !== exp) begin n_fail++; $display("FAIL simul_head: got %0h want %0h", head, exp); end
    for (int i = 0; i < 11; i++) send(8'h20 + 8'(i), a);
    n_tests++; if (bus.count !== 5'd16) begin n_fail++; $display("FAIL simul_full: got %0d want 16", bus.count); end
    for (int i = 0; i < 10 && bus.out_req !== 1'b1; i++) tick();
    bus.in_data = 8'hEE; bus.in_req = 1'b1; bus.out_ack = 1'b1;
    tick();
    bus.in_req = 1'b0; bus.out_ack = 1'b0;
    void'(mq.pop_front());
    m_ovf = 1'b1;
    n_tests++; if (int'(bus.count) !== mq.size()) begin n_fail++; $display("FAIL simul_count16: got %0d want %0d", bus.count, mq.size()); end
    n_tests++; if (bus.overflow !== m_ovf) begin n_fail++; $display("FAIL simul_ovf: got %0b want 1", bus.overflow); end
    tick();
    for (int i = 0; i < 15; i++) begin
      recv(0, b, got, st);
      exp = mq.pop_front();
      n_tests++; if (!got || b !== exp) begin n_fail++; $display("FAIL simul_drain[%0d]: got %0h (req %0b) want %0h", i, b, got, exp); end
    end
    n_tests++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL simul_count_end: got %0d want 0", bus.count); end
  endtask

  task automatic test_handshake();
    bit a, got, st;
    logic [7:0] b;
    int pulses;
    do_reset();
    bus.out_ack = 1'b1;
    repeat (3) tick();
    bus.out_ack = 1'b0;
    n_tests++; if (bus.count !== 5'd0 || bus.out_req !== 1'b0) begin n_fail++; $display("FAIL hs_ack_empty: got count %0d req %0b want 0 0", bus.count, bus.out_req); end
    bus.in_data = 8'h33; bus.in_req = 1'b1;
    pulses = 0;
    repeat (10) begin
      tick();
      if (bus.in_ack === 1'b1) pulses++;
    end
    bus.in_req = 1'b0;
    tick();
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL hs_held_pulses: got %0d want 1", pulses); end
    n_tests++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL hs_held_count: got %0d want 1", bus.count); end
    send(8'h34, a);
    recv(2, b, got, st);
    n_tests++; if (!got || b !== 8'h33 || !st) begin n_fail++; $display("FAIL hs_first: got %0h (req %0b stable %0b) want 33", b, got, st); end
    bus.out_ack = 1'b1;
    tick();
    tick();
    bus.out_ack = 1'b0;
    n_tests++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL hs_stray_ack: got %0d want 1", bus.count); end
    recv(4, b, got, st);
    n_tests++; if (!got || b !== 8'h34 || !st) begin n_fail++; $display("FAIL hs_second: got %0h (req %0b stable %0b) want 34", b, got, st); end
    n_tests++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL hs_count_end: got %0d want 0", bus.count); end
  endtask

  task automatic test_reset_mid();
    bit a, got, st;
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 17; i++) send(8'h60 + 8'(i), a);
    for (int i = 0; i < 9; i++) recv(0, b, got, st);
    for (int i = 0; i < 5 && bus.out_req !== 1'b1; i++) tick();
    n_tests++; if (bus.count !== 5'd7 || bus.out_req !== 1'b1 || bus.overflow !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got count %0d req %0b ovf %0b want 7 1 1", bus.count, bus.out_req, bus.overflow); end
    bus.in_data = 8'h5A; bus.in_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.out_req !== 1'b0 || bus.in_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_async_hs: got req %0b ack %0b want 0 0", bus.out_req, bus.in_ack); end
    n_tests++; if (bus.count !== 5'd0 || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_async_state: got count %0d ovf %0b want 0 0", bus.count, bus.overflow); end
    repeat (2) tick();
    rst_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    tick();
    n_tests++; if (bus.in_ack !== 1'b1 || bus.count !== 5'd1) begin n_fail++; $display("FAIL rmid_new_byte: got ack %0b count %0d want 1 1", bus.in_ack, bus.count); end
    bus.in_req = 1'b0;
    tick();
    recv(1, b, got, st);
    n_tests++; if (!got || b !== 8'h5A) begin n_fail++; $display("FAIL rmid_pass: got %0h (req %0b) want 5a", b, got); end
    n_tests++; if (bus.count !== 5'd0 || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_end: got count %0d ovf %0b want 0 0", bus.count, bus.overflow); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_order();
    test_wrap();
    test_simultaneous();
    test_handshake();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d checks failed so far", n_fail, n_tests);
    $fatal(1, "watchdog");
  end
endmodule
